// File: rtl/sap2_prog_loader.sv
// sap2_prog_loader: 4-phase pin handshake loader writing a header-described byte stream into SAP-2 memory
module sap2_prog_loader #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              LOAD_EN,
    input  logic              STB,
    input  logic [DATA_W-1:0] DIN,
    output logic              ACK,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DATA,
    output logic              MEM_WE,
    output logic              CPU_HOLD,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [ADDR_W-1:0] BYTES_LEFT
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] A_LO = 3'd1;
    localparam logic [2:0] A_HI = 3'd2;
    localparam logic [2:0] L_LO = 3'd3;
    localparam logic [2:0] L_HI = 3'd4;
    localparam logic [2:0] DATA = 3'd5;
    localparam logic [2:0] WR   = 3'd6;
    localparam logic [2:0] FIN  = 3'd7;
    logic [SYNC_STAGES-1:0] en_sync, stb_sync;
    logic [2:0]             state;
    logic [DATA_W-1:0]      len_lo;
    logic [ADDR_W-1:0]      len;
    logic                   stb_d, en_s, stb_s, cap, take;
    assign en_s  = en_sync[SYNC_STAGES-1];
    assign stb_s = stb_sync[SYNC_STAGES-1];
    assign cap   = stb_s & ~stb_d & ~ACK;
    assign take  = cap & en_s & (state inside {A_LO, A_HI, L_LO, L_HI, DATA});
    assign len   = ADDR_W'({DIN, len_lo});
    always_ff @(posedge CLK) begin
        if (RST) begin
            en_sync    <= '0;
            stb_sync   <= '0;
            stb_d      <= 1'b0;
            state      <= IDLE;
            len_lo     <= '0;
            ACK        <= 1'b0;
            MEM_ADDR   <= '0;
            MEM_DATA   <= '0;
            MEM_WE     <= 1'b0;
            CPU_HOLD   <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
            BYTES_LEFT <= '0;
        end else begin
            en_sync  <= {en_sync[SYNC_STAGES-2:0], LOAD_EN};
            stb_sync <= {stb_sync[SYNC_STAGES-2:0], STB};
            stb_d    <= stb_s;
            MEM_WE   <= 1'b0;
            ACK      <= take | (ACK & stb_s);
            case (state)
                IDLE: if (en_s) begin
                    state    <= A_LO;
                    DONE     <= 1'b0;
                    ERR      <= 1'b0;
                    CPU_HOLD <= 1'b1;
                end
                FIN: if (!en_s) begin
                    state    <= IDLE;
                    CPU_HOLD <= 1'b0;
                end
                default: begin
                    if (state == WR) begin
                        MEM_ADDR   <= MEM_ADDR + ADDR_W'(1);
                        BYTES_LEFT <= BYTES_LEFT - ADDR_W'(1);
                    end
                    if (!en_s) begin
                        state    <= IDLE;
                        BUSY     <= 1'b0;
                        ERR      <= 1'b1;
                        CPU_HOLD <= 1'b0;
                    end else if (state == WR) begin
                        state <= (BYTES_LEFT == ADDR_W'(1)) ? FIN : DATA;
                        if (BYTES_LEFT == ADDR_W'(1)) begin
                            BUSY <= 1'b0;
                            DONE <= 1'b1;
                        end
                    end else if (take) begin
                        case (state)
                            A_LO: begin
                                MEM_ADDR <= ADDR_W'(DIN);
                                BUSY     <= 1'b1;
                                state    <= A_HI;
                            end
                            A_HI: begin
                                MEM_ADDR <= ADDR_W'({DIN, MEM_ADDR[DATA_W-1:0]});
                                state    <= L_LO;
                            end
                            L_LO: begin
                                len_lo <= DIN;
                                state  <= L_HI;
                            end
                            L_HI: begin
                                BYTES_LEFT <= len;
                                state      <= (len == '0) ? FIN : DATA;
                                if (len == '0) begin
                                    BUSY <= 1'b0;
                                    DONE <= 1'b1;
                                end
                            end
                            DATA: begin
                                MEM_DATA <= DIN;
                                MEM_WE   <= 1'b1;
                                state    <= WR;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sap2_prog_loader.sv
// tb_sap2_prog_loader: transaction-level model of loads checked against the loader's write port and status pins
module tb_sap2_prog_loader;
    localparam int SS = 2;
    logic        CLK = 1'b0, RST = 1'b1, LOAD_EN = 1'b0, STB = 1'b0;
    logic [7:0]  DIN = '0;
    logic        ACK, MEM_WE, CPU_HOLD, BUSY, DONE, ERR;
    logic [15:0] MEM_ADDR, BYTES_LEFT;
    logic [7:0]  MEM_DATA;
    int          checks = 0, passes = 0, nwr = 0, remaining = 0, base;
    logic [23:0] exp_q[$];
    logic [23:0] e;
    logic [15:0] wa[256];
    logic [7:0]  wd[256];
    logic [7:0]  ld[16];
    always #5 CLK = ~CLK;
    sap2_prog_loader #(.ADDR_W(16), .DATA_W(8), .SYNC_STAGES(SS)) dut (
        .CLK(CLK), .RST(RST), .LOAD_EN(LOAD_EN), .STB(STB), .DIN(DIN),
        .ACK(ACK), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_WE(MEM_WE),
        .CPU_HOLD(CPU_HOLD), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .BYTES_LEFT(BYTES_LEFT)
    );
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    always @(negedge CLK) begin
        if (!RST && MEM_WE) begin
            chk("we_expected", 64'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("we_addr", MEM_ADDR, e[23:8]);
                chk("we_data", MEM_DATA, e[7:0]);
                chk("we_bytes_left", BYTES_LEFT, 64'(remaining));
                chk("we_ack", ACK, 1);
                chk("we_hold_busy", {CPU_HOLD, BUSY}, 2'b11);
                remaining--;
            end
            if (nwr < 256) begin
                wa[nwr] = MEM_ADDR;
                wd[nwr] = MEM_DATA;
            end
            nwr++;
        end
    end
    task automatic send_byte(input logic [7:0] b, input int hold);
        int n;
        @(negedge CLK);
        DIN = b;
        STB = 1'b1;
        n = 0;
        while (ACK !== 1'b1 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        chk("ack_rise", ACK, 1);
        if (hold > 0) begin
            DIN = ~b;
            repeat (hold) @(negedge CLK);
            chk("ack_held", ACK, 1);
        end
        STB = 1'b0;
        n = 0;
        while (ACK !== 1'b0 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        chk("ack_fall", ACK, 0);
        if (hold > 0) chk("ack_drop_latency_ok", 64'(n <= SS + 1), 1);
        repeat ($urandom_range(0, 2)) @(negedge CLK);
    endtask
    task automatic send_header(input logic [15:0] addr, input logic [15:0] len);
        LOAD_EN = 1'b1;
        repeat (2 * SS + 2) @(negedge CLK);
        chk("start_hold", CPU_HOLD, 1);
        chk("start_done_err_clear", {DONE, ERR}, 2'b00);
        send_byte(addr[7:0], 0);
        chk("busy_after_first_hdr", BUSY, 1);
        send_byte(addr[15:8], 0);
        send_byte(len[7:0], 0);
        send_byte(len[15:8], 0);
        remaining = int'(len);
    endtask
    task automatic do_load(input logic [15:0] addr, input int len, input int abort_after, input int hold_idx);
        send_header(addr, 16'(len));
        for (int i = 0; i < len; i++) begin
            if (i == abort_after) break;
            exp_q.push_back({addr + 16'(i), ld[i]});
            send_byte(ld[i], (i == hold_idx) ? 20 : 0);
        end
        repeat (3) @(negedge CLK);
        chk("writes_drained", exp_q.size(), 0);
        if (abort_after >= 0) begin
            LOAD_EN = 1'b0;
            repeat (2 * SS + 2) @(negedge CLK);
            chk("abort_err_done_busy_hold", {ERR, DONE, BUSY, CPU_HOLD}, 4'b1000);
        end else begin
            chk("end_done_busy_err_hold", {DONE, BUSY, ERR, CPU_HOLD}, 4'b1001);
            chk("end_bytes_left", BYTES_LEFT, 0);
            LOAD_EN = 1'b0;
            repeat (2 * SS + 2) @(negedge CLK);
            chk("release_hold_done", {CPU_HOLD, DONE}, 2'b01);
        end
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        repeat (3) @(negedge CLK);
        chk("reset_outputs", {ACK, MEM_ADDR, MEM_DATA, MEM_WE, CPU_HOLD, BUSY, DONE, ERR, BYTES_LEFT}, 0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        base = nwr;
        ld[0] = 8'hAA; ld[1] = 8'hBB; ld[2] = 8'hCC;
        do_load(16'h8000, 3, -1, -1);
        chk("t1_count", nwr - base, 3);
        chk("t1_w0", {wa[base], wd[base]}, 24'h8000AA);
        chk("t1_w1", {wa[base+1], wd[base+1]}, 24'h8001BB);
        chk("t1_w2", {wa[base+2], wd[base+2]}, 24'h8002CC);
        base = nwr;
        do_load(16'hFFFF, 0, -1, -1);
        chk("t2_no_writes", nwr - base, 0);
        base = nwr;
        ld[0] = 8'h11; ld[1] = 8'h22;
        do_load(16'hFFFF, 2, -1, -1);
        chk("t3_w0", {wa[base], wd[base]}, 24'hFFFF11);
        chk("t3_w1", {wa[base+1], wd[base+1]}, 24'h000022);
        base = nwr;
        for (int i = 0; i < 5; i++) ld[i] = 8'($urandom);
        do_load(16'h2000, 5, 2, -1);
        chk("t4_two_writes", nwr - base, 2);
        base = nwr;
        ld[0] = 8'h5A; ld[1] = 8'hC3;
        do_load(16'h4000, 2, -1, 0);
        chk("t5_two_writes", nwr - base, 2);
        chk("t5_w0", {wa[base], wd[base]}, 24'h40005A);
        send_header(16'h1234, 16'd4);
        exp_q.push_back({16'h1234, 8'h77});
        send_byte(8'h77, 0);
        repeat (2) @(negedge CLK);
        chk("t6_pre_reset_hold_busy", {CPU_HOLD, BUSY}, 2'b11);
        RST = 1'b1;
        LOAD_EN = 1'b0;
        STB = 1'b0;
        @(negedge CLK);
        chk("t6_reset_outputs", {ACK, MEM_ADDR, MEM_DATA, MEM_WE, CPU_HOLD, BUSY, DONE, ERR, BYTES_LEFT}, 0);
        RST = 1'b0;
        exp_q.delete();
        remaining = 0;
        ld[0] = 8'h01; ld[1] = 8'h02; ld[2] = 8'h03;
        do_load(16'h0100, 3, -1, -1);
        for (int k = 0; k < 8; k++) begin
            int len;
            logic [15:0] a;
            len = $urandom_range(1, 6);
            a = ($urandom_range(0, 1) == 1) ? 16'(16'hFFFF - $urandom_range(0, 4)) : 16'($urandom);
            for (int i = 0; i < len; i++) ld[i] = 8'($urandom);
            do_load(a, len, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1,
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/sap2_prog_loader.md
Name: sap2_prog_loader

Overview:
- Pin-driven program loader sitting directly upstream of the SAP-2 core (`top`).
- Receives a byte stream on the chip's dedicated inputs using a 4-phase strobe/ack handshake and writes it into SAP-2 memory through the memory write port.
- Holds the CPU in reset while a load is in progress, then releases it so the core starts executing the loaded program.

Parameters:
- ADDR_W, 16, memory address width (SAP-2 64K space)
- DATA_W, 8, byte width of DIN and MEM_DATA
- SYNC_STAGES, 2, flip-flop depth of the STB/LOAD_EN synchronizers (minimum 2)

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- LOAD_EN  in  1  asynchronous pin; high requests/keeps load mode
- STB  in  1  asynchronous pin; host data strobe (4-phase)
- DIN  in  DATA_W  host byte; must be stable while STB is high
- ACK  out  1  handshake acknowledge to host
- MEM_ADDR  out  ADDR_W  memory write address
- MEM_DATA  out  DATA_W  memory write data
- MEM_WE  out  1  one-cycle memory write strobe
- CPU_HOLD  out  1  high keeps the SAP-2 core in reset (ORed into its RST)
- BUSY  out  1  high from the first header byte accepted until DONE or abort
- DONE  out  1  sticky high after a complete load, until the next load starts or RST
- ERR  out  1  sticky high after an aborted load, until the next load starts or RST
- BYTES_LEFT  out  ADDR_W  data bytes still expected

Behaviour:
- **Interface basis.** One clock (CLK); reset RST is synchronous and active-high. All outputs are registered.
- **Reset values.** All outputs are 0 at reset; FSM goes to IDLE.
- **Synchronizers.** LOAD_EN and STB each pass through SYNC_STAGES flops, giving EN_s and STB_s.
  - Capture event = STB_s rising (STB_s=1 and previous STB_s=0).
  - DIN is sampled on the capture-event cycle; it is not synchronized, and the host guarantees stability.
- **FSM states:** IDLE, A_LO, A_HI, L_LO, L_HI, DATA, WR, FIN.
  - IDLE:
    - EN_s=1 → A_LO.
    - On that transition, clear DONE and ERR and set CPU_HOLD=1.
  - A_LO → A_HI → L_LO → L_HI: each advances on a capture event, storing the start address low byte, address high byte, length low byte and length high byte in that order. Stores are byte-wise; with the default widths the two address bytes fill MEM_ADDR.
  - Leaving A_LO (first header byte accepted) sets BUSY=1.
  - Leaving L_HI:
    - Load BYTES_LEFT = length.
    - If length==0 → FIN; otherwise → DATA.
  - DATA: on a capture event, latch DIN into MEM_DATA → WR.
  - WR (one cycle):
    - MEM_WE=1 with the current MEM_ADDR.
    - On the next cycle, MEM_ADDR increments mod 2^ADDR_W (FFFF wraps to 0000) and BYTES_LEFT decrements.
    - If the pre-decrement BYTES_LEFT==1 → FIN; otherwise → DATA.
  - FIN:
    - BUSY=0, DONE=1.
    - Stay in FIN until EN_s=0, then → IDLE and CPU_HOLD=0.
- **ACK (4-phase).**
  - ACK rises on the cycle after each capture event.
  - For data bytes, ACK rises in the same cycle as MEM_WE.
  - ACK falls on the first cycle STB_s=0.
  - A new byte is never captured while ACK=1.
- **Abort.** EN_s falling in any state other than IDLE or FIN:
  - Go to IDLE the next cycle with BUSY=0, ERR=1 and CPU_HOLD=0.
  - Leave MEM_WE=0; an in-flight WR cycle still completes its write first.
- **Simultaneous events.** A capture event and EN_s falling in the same cycle → the abort wins and the byte is discarded.
- **Reset mid-load.** RST returns the block to IDLE with all outputs 0; memory contents already written are left untouched.
- **Throughput.** Bounded by the host handshake; minimum 2×SYNC_STAGES+2 cycles per byte.

Test Plan:
1. **Full load:** RST, LOAD_EN=1, bytes 00,80,03,00 then AA,BB,CC.
   - MEM_WE pulses exactly 3 times, at addr 8000/8001/8002 with AA/BB/CC.
   - BYTES_LEFT steps 3→2→1→0; DONE=1; CPU_HOLD stays 1 until LOAD_EN=0, then 0.
2. **Zero length:** header FF,FF,00,00.
   - Goes straight to FIN with no MEM_WE; DONE=1, ERR=0.
3. **Address wrap:** header FF,FF,02,00, data 11,22.
   - Writes 11@FFFF and 22@0000.
4. **Abort:** LOAD_EN dropped after the 2nd data byte of a length-5 load.
   - ERR=1, DONE=0, BUSY=0, CPU_HOLD=0; exactly 2 writes occurred.
5. **Handshake hold:** STB held high for 20 cycles with DIN changing after ACK.
   - Only one byte is captured; ACK stays high until STB falls, then drops within SYNC_STAGES+1 cycles.
6. **Sync reset:** RST asserted mid-DATA.
   - All outputs 0 on the following edge; a new load then completes normally with DONE cleared at start.
